// File: rtl/mac_pkg.sv
// Shared definitions for the MAC engine: default widths and the controller state encoding.
package mac_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_ACC_W  = 2 * DEF_DATA_W + DEF_ADDR_W;

    // One element costs s1..s6; s7 hands the sum to out_q.
    typedef enum logic [2:0] {
        s0_idle     = 3'd0,
        s1_load     = 3'd1,
        s2_wait_ld  = 3'd2,
        s3_mul      = 3'd3,
        s4_wait_mul = 3'd4,
        s5_acc      = 3'd5,
        s6_cmp      = 3'd6,
        s7_out      = 3'd7
    } mac_state_e;

endpackage

// File: rtl/mac_operand_ram.sv
// Operand storage: DEPTH x DATA_W, synchronous write, asynchronous read, no reset.
module mac_operand_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-edge read of a written address sees the old word.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_datapath.sv
// MAC datapath: operand memories, element counter, multiply and accumulate,
// sequenced entirely by the controller's load/count strobes.
module mac_datapath
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned ACC_W  = 2 * DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic              ld_a,
    input  logic              ld_b,
    input  logic              ld_m,
    input  logic              ld_acc,
    input  logic              ld_out,
    input  logic              count_enb,
    input  logic              count_reset,
    output logic              CMP,
    output logic [ACC_W-1:0]  out_q
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [PROD_W-1:0] m_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] rd_addr;

    assign rd_addr = cnt[ADDR_W-1:0];

    mac_operand_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram_a (
        .clk     (clk),
        .wr_en   (wr_en & ~wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_a)
    );

    mac_operand_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram_b (
        .clk     (clk),
        .wr_en   (wr_en & wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_b)
    );

    // Element counter is one bit wider than the address so len = DEPTH does not wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (count_reset) begin
            cnt <= '0;
        end else if (count_enb) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Operand registers read at the pre-increment count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (ld_a) begin
                a_q <= rd_a;
            end
            if (ld_b) begin
                b_q <= rd_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0;
        end else if (ld_m) begin
            m_q <= PROD_W'(a_q) * PROD_W'(b_q);
        end
    end

    // ld_out wins over ld_acc: the old sum is published and the accumulator restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else if (ld_out) begin
            out_q <= acc_q;
            acc_q <= '0;
        end else if (ld_acc) begin
            acc_q <= acc_q + ACC_W'(m_q);
        end
    end

    assign CMP = (cnt < len);

endmodule

// File: tb/tb_mac_datapath.sv
// Bench for mac_datapath: plays the controller sequence, predicts dot products
// from a memory image, and scores out_q whenever the emulated done is raised.
module tb_mac_datapath;
    import mac_pkg::*;

    localparam int unsigned DATA_W = DEF_DATA_W;
    localparam int unsigned ADDR_W = DEF_ADDR_W;
    localparam int unsigned ACC_W  = DEF_ACC_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   len;
    logic              ld_a, ld_b, ld_m, ld_acc, ld_out, count_enb, count_reset;
    logic              CMP;
    logic [ACC_W-1:0]  out_q;

    logic              done;
    mac_state_e        st;
    longint unsigned   ma [DEPTH];
    longint unsigned   mb [DEPTH];
    longint unsigned   exp_q [$];
    longint unsigned   last_out;
    int                tests = 0;
    int                fails = 0;

    mac_datapath dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .len         (len),
        .ld_a        (ld_a),
        .ld_b        (ld_b),
        .ld_m        (ld_m),
        .ld_acc      (ld_acc),
        .ld_out      (ld_out),
        .count_enb   (count_enb),
        .count_reset (count_reset),
        .CMP         (CMP),
        .out_q       (out_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (state %s): got %0d, expected %0d", name, st.name(), act, exp);
        end
    endtask

    task automatic ctl_idle();
        ld_a = 0; ld_b = 0; ld_m = 0; ld_acc = 0; ld_out = 0;
        count_enb = 0; count_reset = 0;
    endtask

    task automatic write_mem(input bit sel, input int unsigned addr, input int unsigned data);
        @(negedge clk);
        wr_en = 1; wr_sel = sel;
        wr_addr = ADDR_W'(addr); wr_data = DATA_W'(data);
        if (sel) mb[addr] = data; else ma[addr] = data;
        @(posedge clk);
        #1 wr_en = 0;
    endtask

    task automatic load_vectors(input int unsigned n, input int unsigned a[$], input int unsigned b[$]);
        for (int i = 0; i < int'(n); i++) begin
            write_mem(1'b0, i, a[i]);
            write_mem(1'b1, i, b[i]);
        end
    endtask

    // One controller run; abort pulls rst during the third s5.
    task automatic run(input int unsigned l, input bit abort);
        int unsigned     n;
        longint unsigned exp;
        n   = (l == 0) ? 1 : l;
        exp = 0;
        for (int i = 0; i < int'(n); i++) exp += ma[i] * mb[i];
        if (!abort) exp_q.push_back(exp);
        @(negedge clk);
        ctl_idle(); st = s0_idle; len = (ADDR_W+1)'(l);
        for (int i = 0; i < int'(n); i++) begin
            @(negedge clk); ctl_idle(); st = s1_load; ld_a = 1; ld_b = 1; count_enb = 1;
            @(negedge clk); ctl_idle(); st = s2_wait_ld;
            @(negedge clk); ctl_idle(); st = s3_mul; ld_m = 1;
            @(negedge clk); ctl_idle(); st = s4_wait_mul;
            @(negedge clk); ctl_idle(); st = s5_acc; ld_acc = 1;
            if (abort && i == 2) begin
                #2 rst = 1;
                #1;
                check("rst_cnt", dut.cnt, 0);
                check("rst_a_q", dut.a_q, 0);
                check("rst_b_q", dut.b_q, 0);
                check("rst_m_q", dut.m_q, 0);
                check("rst_acc_q", dut.acc_q, 0);
                check("rst_out_q", out_q, 0);
                ctl_idle(); st = s0_idle;
                last_out = 0;
                @(negedge clk); rst = 0;
                return;
            end
            @(negedge clk); ctl_idle(); st = s6_cmp;
            check("cnt_s6", dut.cnt, i + 1);
            check("cmp_s6", CMP, (i + 1 < int'(l)) ? 1 : 0);
        end
        @(negedge clk); ctl_idle(); st = s7_out; ld_out = 1; count_reset = 1;
        check("out_hold", out_q, last_out);
        @(negedge clk); ctl_idle(); st = s0_idle; done = 1; last_out = exp;
        @(negedge clk); done = 0;
    endtask

    // Scoreboard monitor: compare out_q against the oldest prediction on each done.
    initial begin
        forever begin
            @(posedge done);
            #2;
            if (exp_q.size() == 0) check("sb_unexpected_done", 1, 0);
            else                   check("sb_out_q", out_q, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned     va [$];
        int unsigned     vb [$];
        longint unsigned p;
        rst = 1; done = 0; st = s0_idle; last_out = 0;
        wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0; len = 5'd4;
        ctl_idle();
        for (int i = 0; i < int'(DEPTH); i++) begin ma[i] = 0; mb[i] = 0; end

        #12;
        check("reset_out_q", out_q, 0);
        check("reset_cnt", dut.cnt, 0);
        check("reset_acc_q", dut.acc_q, 0);
        check("reset_cmp_len4", CMP, 1);
        len = 5'd0; #1;
        check("reset_cmp_len0", CMP, 0);
        @(negedge clk); rst = 0;

        va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8};
        load_vectors(4, va, vb);
        run(4, 1'b0);

        va = '{}; vb = '{};
        for (int i = 0; i < int'(DEPTH); i++) begin va.push_back(255); vb.push_back(255); end
        load_vectors(DEPTH, va, vb);
        run(DEPTH, 1'b0);

        write_mem(1'b0, 0, 9); write_mem(1'b1, 0, 9);
        run(1, 1'b0);
        run(0, 1'b0);

        va = '{3, 5}; vb = '{4, 6};
        load_vectors(2, va, vb);
        run(2, 1'b0);
        va = '{1, 1}; vb = '{1, 1};
        load_vectors(2, va, vb);
        run(2, 1'b0);

        va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8};
        load_vectors(4, va, vb);
        run(4, 1'b1);
        run(4, 1'b0);

        // Priority: count_reset over count_enb, ld_out over ld_acc.
        p = ma[0] * mb[0];
        @(negedge clk); ctl_idle(); ld_a = 1; ld_b = 1; count_enb = 1;
        @(negedge clk); ctl_idle(); ld_m = 1;
        @(negedge clk); ctl_idle(); ld_acc = 1;
        @(negedge clk); ctl_idle(); ld_acc = 1;
        @(negedge clk); ctl_idle();
        check("prio_pre_cnt", dut.cnt, 1);
        check("prio_pre_acc", dut.acc_q, 2 * p);
        count_reset = 1; count_enb = 1; ld_acc = 1; ld_out = 1;
        @(negedge clk); ctl_idle();
        check("prio_cnt", dut.cnt, 0);
        check("prio_out_q", out_q, 2 * p);
        check("prio_acc_q", dut.acc_q, 0);
        last_out = 2 * p;

        for (int r = 0; r < 8; r++) begin
            int unsigned l;
            l = (r == 3) ? 0 : $urandom_range(1, DEPTH);
            va = '{}; vb = '{};
            for (int i = 0; i < int'(DEPTH); i++) begin
                va.push_back($urandom_range(0, 255));
                vb.push_back($urandom_range(0, 255));
            end
            load_vectors((l == 0) ? 1 : l, va, vb);
            run(l, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
